stream_demultiplexer: RTL and testbench
=======================================

# stream_demultiplexer

Registered 1-to-2^ORDER stream demultiplexer: accepts one WIDTH-bit beat per cycle with a destination index and delivers it to exactly one of NO_OF_OUTPUTS downstream channels under valid/ready flow control. It is the distribution counterpart of the combinational `Multiplexer` in the common library. It fans a single producer, such as a fetch or response path, out to several consumers such as per-way or per-unit queues. It adds one register stage so that downstream ready never has to close timing through the producer's logic.

## Interface
- ORDER, 2, fan-out is 2^ORDER channels
- WIDTH, 32, data beat width in bits
- NO_OF_OUTPUTS (localparam), 1 << ORDER, number of output channels
- CLK  input  1  rising-edge clock
- RSTN  input  1  asynchronous, active-low reset; one clock; reset is asynchronous assert, and all state clears immediately on assertion
- IN_DATA  input  WIDTH  upstream beat
- IN_SELECT  input  ORDER  destination channel of the beat
- IN_VALID  input  1  upstream beat valid
- IN_READY  output  1  block can accept a beat this cycle
- OUT_DATA  output  WIDTH  beat broadcast to all channels; meaningful only where OUT_VALID is set
- OUT_VALID  output  NO_OF_OUTPUTS  one-hot or zero; bit k means the beat is for channel k
- OUT_READY  input  NO_OF_OUTPUTS  per-channel downstream ready

## Operation
- Transfer in: IN_VALID && IN_READY at a rising CLK edge.
- Transfer out: OUT_VALID[k] && OUT_READY[k] at a rising CLK edge.
- OUT_READY bits for channels other than the held beat's channel are ignored.
- Holding register: data, select and a full flag.
- OUT_VALID equals the one-hot decode of the held select when full, and zero when empty.
- OUT_DATA shows the held data. When empty it holds its last value; after reset it is 0.
- Baseline (no skid), two states:
  - EMPTY: IN_READY = 1. An in-transfer loads the register and moves to FULL.
  - FULL: IN_READY = OUT_READY[held_sel].
  - FULL, out-transfer with a simultaneous in-transfer: reload the register and stay in FULL. This gives full throughput on back-to-back beats, including to different channels.
  - FULL, out-transfer without an in-transfer: move to EMPTY.
  - FULL, no out-transfer: hold data, select and valid stable. No change is allowed while stalled.
- Ordering: beats leave in acceptance order, even when they go to different channels. There is no bypass or reordering.
- Once asserted, OUT_VALID[k] stays asserted with stable OUT_DATA until the beat is accepted.
- Reset values:
  - State EMPTY.
  - OUT_VALID = 0.
  - OUT_DATA = 0.
  - Internal select = 0.
  - IN_READY = 1 when RSTN is high after reset.
  - IN_READY = 0 while RSTN is low.
- Reset mid-operation: held beats are dropped, not delivered, and OUT_VALID drops asynchronously.

## Timing
- Latency: a beat accepted at edge n is valid on its channel from edge n and can be consumed at edge n+1 at the earliest.
- Throughput: 1 beat/cycle while the targeted consumers keep ready high.
- Baseline combinational path: OUT_READY → IN_READY, through a NO_OF_OUTPUTS:1 select.
- No combinational path from IN_* to OUT_*.
- With DEMUX_SKID_EN, IN_READY is a pure register output.

## Configuration
- DEMUX_SKID_EN undefined: the baseline behaviour described above.
- DEMUX_SKID_EN defined: adds a second skid register and uses three states, EMPTY, ONE and TWO.
  - IN_READY is registered and equals (state != TWO).
  - ONE, stalled, with an in-transfer: the beat goes to the skid register and the state moves to TWO.
  - TWO, out-transfer: the skid beat moves to the main register and the state moves to ONE. IN_READY is 0 in TWO, so no simultaneous in-transfer is possible.
  - Latency and ordering are unchanged, and throughput is still 1 beat/cycle.
  - Reset clears both registers.

## Structure
- Shared package stream_demux_pkg:
  - State encoding typedef: EMPTY, ONE, TWO.
  - A one-hot decode function select → NO_OF_OUTPUTS vector, so that no duplicate decoder is written per instance.
- Natural sub-module stream_demux_slice: a single-entry valid/data/select register with load/hold/clear. It is instantiated once in the baseline and twice with DEMUX_SKID_EN.
- The top level holds the FSM, the ready select and the OUT_VALID decode.

## Test plan
- Reset: RSTN low mid-stream with channel 2 holding a beat → OUT_VALID = 0 immediately, OUT_DATA = 0. After release, IN_READY = 1.
- Back-to-back routing: ORDER=2, all OUT_READY=1, beats 0xA0..0xA3 to selects 3,0,2,1 on consecutive cycles → OUT_VALID = 1000,0001,0100,0010 on consecutive cycles with the matching data, and IN_READY never drops.
- Stall isolation: a beat 0x55 to channel 1 with OUT_READY = 1101 → OUT_VALID = 0010 held stable for 5 cycles and IN_READY = 0 (baseline). Raising OUT_READY[1] delivers it in exactly 1 transfer.
- Simultaneous load/unload: FULL with channel 0 ready, and a new beat 0x77 to channel 3 in the same cycle → next cycle OUT_VALID = 1000 with 0x77, and no beat is lost or duplicated.
- Skid (DEMUX_SKID_EN): channel 2 stalled while beats 0x11 and 0x22 are sent → both accepted, then IN_READY = 0. After release, 0x11 is delivered then 0x22, in order, and IN_READY = 1 the cycle after the first delivery.
- Randomized scoreboard: 10k beats with random select, IN_VALID and OUT_READY → per-channel in-order delivery and exactly-once delivery, with the OUT_VALID one-hot/zero invariant holding every cycle.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: FSM state encoding and
// the one-hot channel decoder used by every instance.
package stream_demux_pkg;

   // EMPTY: nothing held; ONE: main register full; TWO: main and skid full.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } demux_state_e;

   // Upper bound on fan-out; callers size-cast the decode to their own width.
   localparam int MAX_OUTPUTS = 256;

   // Select index to one-hot channel vector.
   function automatic logic [MAX_OUTPUTS-1:0] onehot_decode(input int unsigned sel);
      logic [MAX_OUTPUTS-1:0] vec;
      vec = '0;
      if (sel < MAX_OUTPUTS) vec[sel[7:0]] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/stream_demultiplexer_if.sv
// Upstream beat channel and the per-channel downstream handshake of the
// stream demultiplexer. The slave modport is the demultiplexer side; the
// master modport is the producer/consumer side.
interface stream_demultiplexer_if #(
   parameter int ORDER = 2,
   parameter int WIDTH = 32
);
   localparam int NO_OF_OUTPUTS = 1 << ORDER;

   logic [WIDTH-1:0]         IN_DATA;
   logic [ORDER-1:0]         IN_SELECT;
   logic                     IN_VALID;
   logic                     IN_READY;
   logic [WIDTH-1:0]         OUT_DATA;
   logic [NO_OF_OUTPUTS-1:0] OUT_VALID;
   logic [NO_OF_OUTPUTS-1:0] OUT_READY;

   modport slave (
      input  IN_DATA, IN_SELECT, IN_VALID, OUT_READY,
      output IN_READY, OUT_DATA, OUT_VALID
   );

   modport master (
      output IN_DATA, IN_SELECT, IN_VALID, OUT_READY,
      input  IN_READY, OUT_DATA, OUT_VALID
   );
endinterface

// File: rtl/stream_demux_slice.sv
// Single-entry valid/data/select holding register. Load wins over clear;
// clear only drops valid so the data output keeps its last value.
module stream_demux_slice #(
   parameter int ORDER = 2,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   input  logic [ORDER-1:0] load_sel,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [ORDER-1:0] sel
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [ORDER-1:0] sel_q,   sel_d;

   // Next-entry selection: load, clear or hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         sel_d   = load_sel;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   // Entry register; reset drops any held beat immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign sel   = sel_q;

endmodule

// File: rtl/stream_demultiplexer.sv
// Registered 1-to-2^ORDER stream demultiplexer. One beat per cycle is routed
// to the channel named by IN_SELECT; beats leave in acceptance order.
// Optional build macro DEMUX_SKID_EN adds a skid entry so IN_READY comes
// straight from a register instead of through the OUT_READY select.
module stream_demultiplexer
   import stream_demux_pkg::*;
#(
   parameter int ORDER = 2,
   parameter int WIDTH = 32
) (
   input logic                  CLK,
   input logic                  RSTN,
   stream_demultiplexer_if.slave bus
);

   localparam int NO_OF_OUTPUTS = 1 << ORDER;

   demux_state_e     state_q, state_d;

   logic             main_valid;
   logic [WIDTH-1:0] main_data;
   logic [ORDER-1:0] main_sel;
   logic             main_load, main_clear;
   logic [WIDTH-1:0] main_load_data;
   logic [ORDER-1:0] main_load_sel;

   logic             sel_ready;
   logic             in_ready_raw;
   logic             in_fire;
   logic             out_fire;

   // Only the held beat's channel ready matters.
   assign sel_ready = bus.OUT_READY[main_sel];
   assign out_fire  = main_valid && sel_ready;
   assign in_fire   = bus.IN_VALID && in_ready_raw;

   stream_demux_slice #(.ORDER(ORDER), .WIDTH(WIDTH)) u_main (
      .clk       (CLK),
      .rst_n     (RSTN),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_load_data),
      .load_sel  (main_load_sel),
      .valid     (main_valid),
      .data      (main_data),
      .sel       (main_sel)
   );

`ifdef DEMUX_SKID_EN
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic [ORDER-1:0] skid_sel;
   logic             skid_load, skid_clear;
   logic             in_ready_q, in_ready_d;

   stream_demux_slice #(.ORDER(ORDER), .WIDTH(WIDTH)) u_skid (
      .clk       (CLK),
      .rst_n     (RSTN),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_data (bus.IN_DATA),
      .load_sel  (bus.IN_SELECT),
      .valid     (skid_valid),
      .data      (skid_data),
      .sel       (skid_sel)
   );

   assign in_ready_raw = in_ready_q;

   // Three-state control: a stalled beat in ONE spills into the skid entry.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_load_data = bus.IN_DATA;
      main_load_sel  = bus.IN_SELECT;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (out_fire) begin
               if (in_fire) begin
                  main_load = 1'b1;
               end else begin
                  main_clear = 1'b1;
                  state_d    = EMPTY;
               end
            end else if (in_fire) begin
               skid_load = 1'b1;
               state_d   = TWO;
            end
         end
         TWO: begin
            // IN_READY is low here, so only the skid beat can move forward.
            if (out_fire && skid_valid) begin
               main_load      = 1'b1;
               main_load_data = skid_data;
               main_load_sel  = skid_sel;
               skid_clear     = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d = (state_d != TWO);
   end

   // State and registered ready.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end
`else
   // Full entry can take a new beat only in the cycle it drains.
   assign in_ready_raw = (state_q == EMPTY) || sel_ready;

   // Two-state control: reload on simultaneous in/out, drain otherwise.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_load_data = bus.IN_DATA;
      main_load_sel  = bus.IN_SELECT;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_load = 1'b1;
               state_d   = ONE;
            end
         end
         ONE: begin
            if (out_fire) begin
               if (in_fire) begin
                  main_load = 1'b1;
               end else begin
                  main_clear = 1'b1;
                  state_d    = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state_q <= EMPTY;
      else       state_q <= state_d;
   end
`endif

   // Ready is forced low while reset is held.
   assign bus.IN_READY  = RSTN && in_ready_raw;
   assign bus.OUT_DATA  = main_data;
   assign bus.OUT_VALID = main_valid ? NO_OF_OUTPUTS'(onehot_decode(32'(main_sel))) : '0;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Scoreboard bench for stream_demultiplexer: drivers push expected beats,
// a negedge monitor pops and compares on every output transfer.
module tb_stream_demultiplexer;

   localparam int ORDER = 2;
   localparam int WIDTH = 32;
   localparam int N     = 1 << ORDER;

   typedef struct packed {
      logic [ORDER-1:0] sel;
      logic [WIDTH-1:0] data;
   } beat_t;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   stream_demultiplexer_if #(.ORDER(ORDER), .WIDTH(WIDTH)) bus ();

   stream_demultiplexer #(.ORDER(ORDER), .WIDTH(WIDTH)) dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (bus)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q[$];
   bit    rand_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] oh(input logic [ORDER-1:0] s);
      logic [N-1:0] v;
      v = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // Drive one beat; push its expectation once acceptance is certain.
   task automatic send(input logic [WIDTH-1:0] d, input logic [ORDER-1:0] s);
      int  waited;
      bit  done;
      beat_t b;
      waited = 0;
      done   = 0;
      bus.IN_VALID  = 1'b1;
      bus.IN_DATA   = d;
      bus.IN_SELECT = s;
      while (!done) begin
         @(negedge CLK);
         if (bus.IN_READY) begin
            b.sel  = s;
            b.data = d;
            exp_q.push_back(b);
            done = 1;
         end else if (++waited > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat %0h never accepted", d);
            done = 1;
         end
      end
      @(posedge CLK); #1;
      bus.IN_VALID = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   // Monitor: invariant, stall stability and in-order exactly-once delivery.
   logic [N-1:0]     prev_v;
   logic [WIDTH-1:0] prev_d;
   bit               prev_stall = 0;
   always @(negedge CLK) begin
      beat_t e;
      if (!RSTN) begin
         prev_stall = 0;
      end else begin
         check("onehot0", 64'($onehot0(bus.OUT_VALID)), 64'd1);
         if (prev_stall)
            check("stall_hold", 64'({prev_v, prev_d}), 64'({bus.OUT_VALID, bus.OUT_DATA}));
         if (|(bus.OUT_VALID & bus.OUT_READY)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got ch %b data %0h, expected none",
                        bus.OUT_VALID, bus.OUT_DATA);
            end else begin
               e = exp_q.pop_front();
               check("deliver", 64'({bus.OUT_VALID, bus.OUT_DATA}), 64'({oh(e.sel), e.data}));
            end
            prev_stall = 0;
         end else begin
            prev_stall = |bus.OUT_VALID;
            prev_v     = bus.OUT_VALID;
            prev_d     = bus.OUT_DATA;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] b2b_data [4];
      logic [ORDER-1:0] b2b_sel  [4];
      int               wait_cnt;

      bus.IN_VALID  = 1'b0;
      bus.IN_DATA   = '0;
      bus.IN_SELECT = '0;
      bus.OUT_READY = '0;

      // Reset state
      #12;
      check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
      check("rst_out_data",  64'(bus.OUT_DATA),  64'd0);
      check("rst_in_ready_low", 64'(bus.IN_READY), 64'd0);
      step();
      RSTN = 1'b1;
      @(negedge CLK);
      check("rst_in_ready_high", 64'(bus.IN_READY), 64'd1);
      step();

      // Back-to-back routing
      b2b_data[0] = 32'hA0; b2b_sel[0] = 2'd3;
      b2b_data[1] = 32'hA1; b2b_sel[1] = 2'd0;
      b2b_data[2] = 32'hA2; b2b_sel[2] = 2'd2;
      b2b_data[3] = 32'hA3; b2b_sel[3] = 2'd1;
      bus.OUT_READY = '1;
      for (int i = 0; i < 5; i++) begin
         beat_t b;
         if (i < 4) begin
            bus.IN_VALID  = 1'b1;
            bus.IN_DATA   = b2b_data[i];
            bus.IN_SELECT = b2b_sel[i];
         end else begin
            bus.IN_VALID = 1'b0;
         end
         @(negedge CLK);
         if (i < 4) begin
            check("b2b_in_ready", 64'(bus.IN_READY), 64'd1);
            b.sel  = b2b_sel[i];
            b.data = b2b_data[i];
            exp_q.push_back(b);
         end
         if (i > 0) begin
            check("b2b_out_valid", 64'(bus.OUT_VALID), 64'(oh(b2b_sel[i-1])));
            check("b2b_out_data",  64'(bus.OUT_DATA),  64'(b2b_data[i-1]));
         end
         step();
      end
      step();

      // Stall isolation
      bus.OUT_READY = 4'b1101;
      send(32'h55, 2'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("stall_valid", 64'(bus.OUT_VALID), 64'b0010);
         check("stall_data",  64'(bus.OUT_DATA),  64'h55);
`ifndef DEMUX_SKID_EN
         check("stall_in_ready", 64'(bus.IN_READY), 64'd0);
`endif
         step();
      end
      bus.OUT_READY = 4'b1111;
      step();
      @(negedge CLK);
      check("stall_drained", 64'(bus.OUT_VALID), 64'd0);
      step();

      // Simultaneous load/unload
      bus.OUT_READY = 4'b0000;
      send(32'h66, 2'd0);
      bus.OUT_READY = 4'b0001;
      send(32'h77, 2'd3);
      bus.OUT_READY = 4'b0000;
      @(negedge CLK);
      check("simul_valid", 64'(bus.OUT_VALID), 64'b1000);
      check("simul_data",  64'(bus.OUT_DATA),  64'h77);
      step();
      bus.OUT_READY = 4'b1111;
      step();
      step();

`ifdef DEMUX_SKID_EN
      // Skid: channel 2 stalled
      bus.OUT_READY = 4'b1011;
      send(32'h11, 2'd2);
      send(32'h22, 2'd2);
      @(negedge CLK);
      check("skid_full_in_ready", 64'(bus.IN_READY), 64'd0);
      step();
      bus.OUT_READY = 4'b1111;
      @(negedge CLK);
      check("skid_first_data", 64'(bus.OUT_DATA), 64'h11);
      step();
      @(negedge CLK);
      check("skid_in_ready_back", 64'(bus.IN_READY), 64'd1);
      check("skid_second_data",   64'(bus.OUT_DATA), 64'h22);
      step();
      step();
`endif

      // Reset mid-operation with channel 2 holding a beat
      bus.OUT_READY = 4'b0000;
      send(32'hCC, 2'd2);
      #2;
      RSTN = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
      check("midrst_out_data",  64'(bus.OUT_DATA),  64'd0);
      check("midrst_in_ready",  64'(bus.IN_READY),  64'd0);
      step();
      RSTN = 1'b1;
      @(negedge CLK);
      check("postrst_in_ready",  64'(bus.IN_READY),  64'd1);
      check("postrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
      step();

      // Randomized traffic
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(3) == 0) step();
               send($urandom, ORDER'($urandom_range(N - 1)));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               for (int k = 0; k < N; k++) bus.OUT_READY[k] = ($urandom_range(3) != 0);
               step();
            end
         end
      join

      // Drain and confirm nothing is left undelivered
      bus.OUT_READY = '1;
      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 100) begin
         step();
         wait_cnt++;
      end
      check("leftover_beats", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
